// File: rtl/md_pkg.sv
// Shared multiply/divide encodings for the E-stage sequencer and the hazard unit.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MSUB  = 3'd5,
    MD_MTHI  = 3'd6,
    MD_MTLO  = 3'd7
  } md_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/md_alu.sv
// Combinational mult/div datapath producing the pending HI/LO pair.
// Zero latency; no flow control, the sequencer samples the outputs on an accepted start.
module md_alu
  import md_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] p_hi,
  output logic [31:0] p_lo,
  output logic        div_zero
);

  logic [63:0] w_smul;
  logic [63:0] w_umul;
  logic [63:0] w_msub;
  logic        w_sdiv;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_dvd;
  logic [31:0] w_dvs;
  logic [31:0] w_q;
  logic [31:0] w_r;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign w_smul = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_umul = {32'd0, a} * {32'd0, b};
  assign w_msub = {hi, lo} - w_smul;

  // One unsigned divider serves both div and divu; signed div works on magnitudes.
  assign w_sdiv  = (md_op == MD_DIV);
  assign w_a_mag = a[31] ? -a : a;
  assign w_b_mag = b[31] ? -b : b;
  assign w_dvd   = w_sdiv ? w_a_mag : a;
  assign w_dvs   = (b == 32'd0) ? 32'd1 : (w_sdiv ? w_b_mag : b);
  assign w_q     = w_dvd / w_dvs;
  assign w_r     = w_dvd % w_dvs;

  always_comb begin
    p_hi     = hi;
    p_lo     = lo;
    div_zero = 1'b0;
    case (md_op)
      MD_MULT:  {p_hi, p_lo} = w_smul;
      MD_MULTU: {p_hi, p_lo} = w_umul;
      MD_MSUB:  {p_hi, p_lo} = w_msub;
      MD_DIV: begin
        p_lo     = (a[31] ^ b[31]) ? -w_q : w_q;
        p_hi     = a[31] ? -w_r : w_r;
        div_zero = (b == 32'd0);
      end
      MD_DIVU: begin
        p_lo     = w_q;
        p_hi     = w_r;
        div_zero = (b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO owner: mult-class ops commit after MULT_CYCLES, div after DIV_CYCLES, mthi/mtlo in one edge.
// busy is high for the whole run; starts seen while busy are dropped (hazard unit prevents them).
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   r_state;
  md_state_e   w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_p_hi;
  logic [31:0] r_p_lo;
  logic        r_div_zero;
  logic        w_load;
  logic        w_commit;
  logic        w_wr_hi;
  logic        w_wr_lo;
  logic [31:0] w_p_hi;
  logic [31:0] w_p_lo;
  logic        w_div_zero;

  md_alu u_alu (
    .md_op    (md_op),
    .a        (a),
    .b        (b),
    .hi       (r_hi),
    .lo       (r_lo),
    .p_hi     (w_p_hi),
    .p_lo     (w_p_lo),
    .div_zero (w_div_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    w_wr_hi     = 1'b0;
    w_wr_lo     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT, MD_MULTU, MD_MSUB: begin
              w_load      = 1'b1;
              w_cnt_nxt   = 4'(MULT_CYCLES);
              w_state_nxt = ST_RUN;
            end
            MD_DIV, MD_DIVU: begin
              w_load      = 1'b1;
              w_cnt_nxt   = 4'(DIV_CYCLES);
              w_state_nxt = ST_RUN;
            end
            MD_MTHI: w_wr_hi = 1'b1;
            MD_MTLO: w_wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_p_hi     <= 32'd0;
      r_p_lo     <= 32'd0;
      r_div_zero <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_p_hi     <= w_p_hi;
        r_p_lo     <= w_p_lo;
        r_div_zero <= w_div_zero;
      end
      if (w_wr_hi) r_hi <= a;
      if (w_wr_lo) r_lo <= a;
      // Divide by zero still occupies the full window but leaves HI/LO untouched.
      if (w_commit && !r_div_zero) begin
        r_hi <= r_p_hi;
        r_lo <= r_p_lo;
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
